// File: rtl/uart_pkg.sv
// uart_pkg: shared defaults, counter-width helper and lane-order encoding for the UART word packer
package uart_pkg;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_NUM_BYTES = 16;
   typedef enum logic {LANE_MSB_FIRST, LANE_LSB_FIRST} lane_order_e;
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/uart_word_packer_pack_out_reg.sv
// pack_out_reg: output holding register presenting one packed word until the consumer takes it
module pack_out_reg #(
   parameter int WORD_W = 128,
   parameter int CNT_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WORD_W-1:0] load_data,
   input  logic [CNT_W-1:0]  load_count,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [WORD_W-1:0] out_data,
   output logic [CNT_W-1:0]  out_count,
   output logic              slot_free
);
   assign slot_free = !out_valid || out_ready;
   // a load may coincide with a handshake, giving back-to-back words without a bubble
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= load_data;
         out_count <= load_count;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: rtl/uart_word_packer.sv
// uart_word_packer: packs DATA_W-bit UART lanes into NUM_BYTES-lane words with flush and drop reporting
module uart_word_packer import uart_pkg::*; #(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NUM_BYTES = DEF_NUM_BYTES,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   input  logic [DATA_W-1:0]                in_data,
   output logic                             in_ready,
   input  logic                             flush,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [DATA_W*NUM_BYTES-1:0]      out_data,
   output logic [cnt_w(NUM_BYTES)-1:0]      out_count,
   output logic                             drop,
   output logic                             empty,
   output logic                             full
);
   localparam int CNT_W = cnt_w(NUM_BYTES);
   localparam lane_order_e ORDER = MSB_FIRST ? LANE_MSB_FIRST : LANE_LSB_FIRST;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_BYTES);
   logic [CNT_W-1:0] count, count_next, wr_idx;
   logic flush_pend, slot_free, xfer, accept;
   logic [DATA_W-1:0] fill [NUM_BYTES];
   logic [DATA_W*NUM_BYTES-1:0] packed_word;
   // handoff decision on registered state; in_ready looks through out_ready so a full fill can refill in the handoff cycle
   always_comb begin
      xfer       = slot_free && (count == FULL_CNT || (flush_pend && count != '0));
      in_ready   = count != FULL_CNT || xfer;
      accept     = in_valid && in_ready;
      wr_idx     = xfer ? '0 : count;
      count_next = wr_idx + CNT_W'(accept);
   end
   assign full  = count == FULL_CNT;
   assign empty = count == '0 && !out_valid;
   // fill counter, pending flush and the registered drop pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= '0;
         flush_pend <= 1'b0;
         drop       <= 1'b0;
      end else begin
         count      <= count_next;
         flush_pend <= (flush || (flush_pend && !xfer)) && count_next != '0;
         drop       <= in_valid && !in_ready;
      end
   end
   // lane storage; stale lanes beyond count are masked at packing time so no reset is needed
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_BYTES; i++)
         if (accept && wr_idx == CNT_W'(i)) fill[i] <= in_data;
   end
   // place used lanes in arrival order, zeroing unused lanes of a partial word
   always_comb begin
      packed_word = '0;
      for (int i = 0; i < NUM_BYTES; i++)
         if (CNT_W'(i) < count)
            packed_word[((ORDER == LANE_MSB_FIRST) ? NUM_BYTES - 1 - i : i) * DATA_W +: DATA_W] = fill[i];
   end
   pack_out_reg #(.WORD_W(DATA_W * NUM_BYTES), .CNT_W(CNT_W)) u_out (
      .clk        (clk),
      .rst        (rst),
      .load       (xfer),
      .load_data  (packed_word),
      .load_count (count),
      .out_ready  (out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_count  (out_count),
      .slot_free  (slot_free)
   );
endmodule
